instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction-fetch stage of the pipelined MIPS core, the producer side of the decode-stage control interface. It drives the instruction memory, buffers fetched words, and presents one instruction plus its PC+4 to decode each cycle. It consumes the control unit's redirect outputs (PCSrcD, PC_SelD) and branch/jump targets, flushing wrong-path instructions.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset
- DEPTH, 2: instruction buffer entries; power of two, ≥2
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_StallD  in  1  decode stalled; holds decode slot, blocks redirect
- i_PCSrcD  in  1  redirect request from control unit
- i_PC_SelD  in  2  target select: 01 branch, 10 jump, 11 jump-register; 00 = no redirect
- i_PCBranchD / i_PCJumpD / i_RegJumpD  in  32 each  target addresses
- o_imem_req  out  1  fetch request
- o_imem_addr  out  32  word-aligned fetch address
- i_imem_gnt  in  1  request accepted this cycle
- i_imem_rvalid  in  1  in-order read data valid
- i_imem_rdata  in  32  instruction word
- o_InstrD  out  32  decode-slot instruction; 32'h0 (NOP) when empty
- o_PCPlus4D  out  32  PC+4 of decode-slot instruction; 0 when empty
- o_ValidD  out  1  decode slot holds a real instruction

## Operation
- Redirect = i_PCSrcD & ~i_StallD & (i_PC_SelD != 00). Target from i_PC_SelD; bits [1:0] forced to 00.
- Fetch PC: advances by 4 on each accepted request (o_imem_req & i_imem_gnt); loads target on redirect.
- o_imem_req = ~i_rst & ~redirect & (count + outstanding < DEPTH); o_imem_addr = fetch PC. Same-cycle pop does not add space.
- outstanding: +1 per accepted request, −1 per rvalid; simultaneous → unchanged.
- Redirect: buffer emptied, drop := outstanding (minus any rvalid that cycle), response PC := target.
- rvalid with drop > 0: data discarded, drop −1. Otherwise push {rdata, respPC+4}; respPC += 4.
- rvalid in the redirect cycle is always discarded.
- Pop when o_ValidD & ~i_StallD; push+pop in one cycle allowed, including when full.
- Push never occurs when full (the request limit guarantees it); bench asserts this.
- 32-bit address arithmetic wraps modulo 2^32.

## Timing
- Reset cycle and the cycle after: o_imem_req=0 during reset; PC=RESET_PC, buffer empty, outstanding=0, drop=0, o_ValidD=0, o_InstrD=0, o_PCPlus4D=0.
- First request asserted in the first cycle after i_rst deasserts.
- Data latency: word arriving on rvalid in cycle N is visible on o_InstrD in cycle N+1.
- Redirect in cycle N: o_ValidD=0 at N+1; target requested at N+1; first target instruction at decode in cycle (its rvalid)+1.
- Redirect while stalled is ignored. The control unit re-asserts the redirect once the stall releases.
- Reset mid-operation: all state cleared; responses to pre-reset requests are the memory model's responsibility, and the bench must not deliver them.

## Structure
- mips_pkg: PC_SEL_BRANCH/JUMP/JUMPR constants, NOP_INSTR (32'h0), default RESET_PC.
- Sub-module fetch_buffer: synchronous FIFO of DEPTH × 64 bits ({instr, pcplus4}), with push/pop/flush/count and first-word-fall-through head.
- Top level holds the PC, response-PC, outstanding and drop counters, and the target mux.

## Test plan
- Reset, zero-latency memory, no stall → addresses 0,4,8…; o_ValidD from third cycle, o_PCPlus4D 4,8,12 consecutively.
- i_StallD high 3 cycles with buffer full → o_imem_req=0, o_InstrD/o_PCPlus4D held, no loss after release.
- Branch redirect (PC_SelD=01, target 0x100) with 2 outstanding → both old responses dropped, next valid o_PCPlus4D=0x104.
- i_PCSrcD with i_StallD=1 → no redirect; sequential fetch continues unchanged.
- Jump-register target 0x203 → fetch address 0x200; rvalid coinciding with redirect discarded.
- Random gnt/rvalid delays (0–4 cycles) vs reference model → decode stream matches program order, never overflows.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: redirect selects, NOP word,
// default reset PC, the fetch-buffer entry layout and an alignment helper.
package mips_pkg;

   localparam logic [1:0]  PC_SEL_NONE      = 2'b00;
   localparam logic [1:0]  PC_SEL_BRANCH    = 2'b01;
   localparam logic [1:0]  PC_SEL_JUMP      = 2'b10;
   localparam logic [1:0]  PC_SEL_JUMPR     = 2'b11;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'h0000_0004;

   // One buffered instruction together with the PC+4 that decode needs.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pcPlus4;
   } bufEntry_t;

   // Instruction addresses are always word aligned; low two bits are dropped.
   function automatic logic [31:0] wordAlign(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave). Responses return in request order.
interface instr_fetch_unit_if;

   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemGnt;
   logic        imemRvalid;
   logic [31:0] imemRdata;

   modport master (
      output imemReq,
      output imemAddr,
      input  imemGnt,
      input  imemRvalid,
      input  imemRdata
   );

   modport slave (
      input  imemReq,
      input  imemAddr,
      output imemGnt,
      output imemRvalid,
      output imemRdata
   );

endinterface

// File: rtl/instr_fetch_unit_buffer.sv
// fetch_buffer: small synchronous FIFO of fetched instructions with a
// first-word-fall-through head. Flush empties it in one cycle; push and pop
// may happen together, including when full.
module fetch_buffer
   import mips_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_flush,
   input  bufEntry_t     i_data,
   output bufEntry_t     o_head,
   output logic          o_valid,
   output logic [CW-1:0] o_count
);

   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   bufEntry_t     mem_r [DEPTH];
   logic [AW-1:0] wrPtr_r;
   logic [AW-1:0] rdPtr_r;
   logic [CW-1:0] count_r;
   logic          notEmpty_s;
   logic          doPop_s;
   logic          doPush_s;

   // Qualify push/pop; a pop frees the slot a same-cycle push writes into.
   always_comb begin
      notEmpty_s = (count_r != CNT_ZERO);
      doPop_s    = i_pop & notEmpty_s & ~i_flush;
      doPush_s   = i_push & ~i_flush & ((count_r != CNT_FULL) | doPop_s);
   end

   // Pointer and occupancy bookkeeping; flush behaves like a reset.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         wrPtr_r <= PTR_ZERO;
         rdPtr_r <= PTR_ZERO;
         count_r <= CNT_ZERO;
      end else begin
         if (doPush_s) wrPtr_r <= wrPtr_r + PTR_ONE;
         if (doPop_s)  rdPtr_r <= rdPtr_r + PTR_ONE;
         case ({doPush_s, doPop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; cleared on reset so the head never shows stale X.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= '{instr: NOP_INSTR, pcPlus4: 32'h0000_0000};
      end else if (doPush_s) begin
         mem_r[wrPtr_r] <= i_data;
      end
   end

   // Head falls through from storage; an empty buffer presents a NOP entry.
   always_comb begin
      o_valid = notEmpty_s;
      o_count = count_r;
      o_head  = notEmpty_s ? mem_r[rdPtr_r] : '{instr: NOP_INSTR, pcPlus4: 32'h0000_0000};
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage of the pipelined MIPS core. Issues in-order
// instruction-memory requests bounded by free buffer space, squashes
// wrong-path responses after a redirect and feeds decode from fetch_buffer.
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_StallD,
   input  logic                      i_PCSrcD,
   input  logic [1:0]                i_PC_SelD,
   input  logic [31:0]               i_PCBranchD,
   input  logic [31:0]               i_PCJumpD,
   input  logic [31:0]               i_RegJumpD,
   instr_fetch_unit_if.master        imem,
   output logic [31:0]               o_InstrD,
   output logic [31:0]               o_PCPlus4D,
   output logic                      o_ValidD
);

   localparam int              CW       = $clog2(DEPTH) + 1;
   localparam int              SW       = CW + 1;
   localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [SW-1:0]   DEPTH_W  = SW'(DEPTH);

   logic [31:0]   fetchPc_r;
   logic [31:0]   respPc_r;
   logic [CW-1:0] outstanding_r;
   logic [CW-1:0] drop_r;

   logic [31:0]   rawTarget_s;
   logic [31:0]   target_s;
   logic          redirect_s;
   logic [SW-1:0] occupancy_s;
   logic          imemReq_s;
   logic          accept_s;
   logic          dropNow_s;
   logic          push_s;
   logic          pop_s;
   bufEntry_t     pushData_s;
   bufEntry_t     bufHead_s;
   logic          bufValid_s;
   logic [CW-1:0] bufCount_s;

   // Redirect target mux; the low two bits are forced to zero.
   always_comb begin
      rawTarget_s = 32'h0000_0000;
      case (i_PC_SelD)
         PC_SEL_BRANCH: rawTarget_s = i_PCBranchD;
         PC_SEL_JUMP:   rawTarget_s = i_PCJumpD;
         PC_SEL_JUMPR:  rawTarget_s = i_RegJumpD;
         default:       rawTarget_s = 32'h0000_0000;
      endcase
      target_s = wordAlign(rawTarget_s);
   end

   // Request throttle, response steering and decode-slot pop.
   // Space counts in-flight words, so a stale response still holds its slot.
   always_comb begin
      redirect_s  = i_PCSrcD & ~i_StallD & (i_PC_SelD != PC_SEL_NONE);
      occupancy_s = {1'b0, bufCount_s} + {1'b0, outstanding_r};
      imemReq_s   = ~i_rst & ~redirect_s & (occupancy_s < DEPTH_W);
      accept_s    = imemReq_s & imem.imemGnt;
      dropNow_s   = imem.imemRvalid & (redirect_s | (drop_r != CNT_ZERO));
      push_s      = imem.imemRvalid & ~dropNow_s;
      pop_s       = bufValid_s & ~i_StallD;
      pushData_s  = '{instr: imem.imemRdata, pcPlus4: respPc_r + PC_STEP};
   end

   assign imem.imemReq  = imemReq_s;
   assign imem.imemAddr = fetchPc_r;

   // Fetch PC: jumps to the target on redirect, steps on each accepted request.
   always_ff @(posedge i_clk) begin
      if (i_rst)           fetchPc_r <= RESET_PC;
      else if (redirect_s) fetchPc_r <= target_s;
      else if (accept_s)   fetchPc_r <= fetchPc_r + PC_STEP;
      else                 fetchPc_r <= fetchPc_r;
   end

   // Address of the next response that will be kept.
   always_ff @(posedge i_clk) begin
      if (i_rst)           respPc_r <= RESET_PC;
      else if (redirect_s) respPc_r <= target_s;
      else if (push_s)     respPc_r <= respPc_r + PC_STEP;
      else                 respPc_r <= respPc_r;
   end

   // In-flight request count; redirect cycles never accept, so no special case.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         outstanding_r <= CNT_ZERO;
      end else begin
         case ({accept_s, imem.imemRvalid})
            2'b10:   outstanding_r <= outstanding_r + CNT_ONE;
            2'b01:   outstanding_r <= outstanding_r - CNT_ONE;
            default: outstanding_r <= outstanding_r;
         endcase
      end
   end

   // Wrong-path responses still to be discarded after a redirect.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         drop_r <= CNT_ZERO;
      else if (redirect_s)
         drop_r <= outstanding_r - {{(CW-1){1'b0}}, imem.imemRvalid};
      else if (imem.imemRvalid && (drop_r != CNT_ZERO))
         drop_r <= drop_r - CNT_ONE;
      else
         drop_r <= drop_r;
   end

   fetch_buffer #(.DEPTH(DEPTH)) uBuf (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (push_s),
      .i_pop   (pop_s),
      .i_flush (redirect_s),
      .i_data  (pushData_s),
      .o_head  (bufHead_s),
      .o_valid (bufValid_s),
      .o_count (bufCount_s)
   );

   // Decode slot comes straight from the buffer head register.
   always_comb begin
      o_ValidD   = bufValid_s;
      o_InstrD   = bufValid_s ? bufHead_s.instr   : NOP_INSTR;
      o_PCPlus4D = bufValid_s ? bufHead_s.pcPlus4 : 32'h0000_0000;
   end

endmodule
